// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer
// Takes rasterizer (x, y, color) pixels through a small FIFO, drops pixels that
// fall off-screen, and commits the rest to a single-port framebuffer as
// y*H_RES + x. A clear request sweeps every address with zero once the pixels
// accepted before it have been written. Pixels accepted after the request wait
// in the FIFO until the sweep finishes.
module fb_pixel_writer #(
   parameter int H_RES      = 32,
   parameter int V_RES      = 16,
   parameter int ADDR_W     = 9,
   parameter int COLOR_W    = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pix_valid,
   output logic               pix_ready,
   input  logic [31:0]        pix_x,
   input  logic [31:0]        pix_y,
   input  logic [COLOR_W-1:0] pix_color,
   input  logic               clear_req,
   output logic               busy,
   output logic               fb_we,
   output logic [ADDR_W-1:0]  fb_addr,
   output logic [COLOR_W-1:0] fb_wdata,
   output logic [15:0]        write_count,
   output logic [15:0]        clip_count
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int TOTAL = H_RES * V_RES;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);

   typedef enum logic {
      RUN   = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t state, state_next;

   logic [31:0]        fifo_x [FIFO_DEPTH];
   logic [31:0]        fifo_y [FIFO_DEPTH];
   logic [COLOR_W-1:0] fifo_c [FIFO_DEPTH];

   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   count;
   // Entries that were already in the FIFO (or arrived on the same edge) when
   // the clear request was taken; these must drain before the sweep starts.
   logic [PTR_W:0]   pend_left;
   logic             clear_pend;
   logic [ADDR_W-1:0] clr_addr;

   logic push, pop, take_clear, start_clear, clear_write;
   logic [31:0]        head_x, head_y;
   logic [COLOR_W-1:0] head_c;
   logic               head_in_range;

   assign pix_ready = (count < (PTR_W+1)'(FIFO_DEPTH));
   assign push      = pix_valid && pix_ready;
   assign busy      = (count != '0) || clear_pend || (state == CLEAR);

   assign head_x = fifo_x[rd_ptr];
   assign head_y = fifo_y[rd_ptr];
   assign head_c = fifo_c[rd_ptr];
   assign head_in_range = ($signed(head_x) >= 0) && ($signed(head_x) < H_RES) &&
                          ($signed(head_y) >= 0) && ($signed(head_y) < V_RES);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= RUN;
      else     state <= state_next;
   end

   // Next state plus the per-cycle pop / clear-write decisions
   always_comb begin
      state_next  = state;
      pop         = 1'b0;
      take_clear  = 1'b0;
      start_clear = 1'b0;
      clear_write = 1'b0;
      case (state)
         RUN: begin
            if (clear_pend && pend_left == '0) begin
               start_clear = 1'b1;
               clear_write = 1'b1;
               state_next  = CLEAR;
            end else if (count != '0 && (!clear_pend || pend_left != '0)) begin
               pop = 1'b1;
            end
            if (!clear_pend && clear_req) take_clear = 1'b1;
         end
         CLEAR: begin
            clear_write = 1'b1;
            if (clr_addr == LAST_ADDR) state_next = RUN;
         end
         default: state_next = RUN;
      endcase
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
      end
   end

   // FIFO storage needs no reset; occupancy alone says what is valid
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_x[wr_ptr] <= pix_x;
         fifo_y[wr_ptr] <= pix_y;
         fifo_c[wr_ptr] <= pix_color;
      end
   end

   // Clear bookkeeping: pending flag, pre-request drain count, sweep address
   always_ff @(posedge clk) begin
      if (rst) begin
         clear_pend <= 1'b0;
         pend_left  <= '0;
         clr_addr   <= '0;
      end else begin
         if (take_clear) begin
            clear_pend <= 1'b1;
            pend_left  <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
         end else begin
            if (start_clear) clear_pend <= 1'b0;
            if (pop && clear_pend && pend_left != '0) pend_left <= pend_left - (PTR_W+1)'(1);
         end
         if (start_clear)         clr_addr <= ADDR_W'(1);
         else if (state == CLEAR) clr_addr <= clr_addr + ADDR_W'(1);
      end
   end

   // Registered framebuffer port and saturating statistics
   always_ff @(posedge clk) begin
      if (rst) begin
         fb_we       <= 1'b0;
         fb_addr     <= '0;
         fb_wdata    <= '0;
         write_count <= '0;
         clip_count  <= '0;
      end else begin
         fb_we <= 1'b0;
         if (clear_write) begin
            fb_we    <= 1'b1;
            fb_addr  <= start_clear ? '0 : clr_addr;
            fb_wdata <= '0;
         end else if (pop) begin
            if (head_in_range) begin
               fb_we    <= 1'b1;
               fb_addr  <= ADDR_W'(head_y * H_RES + head_x);
               fb_wdata <= head_c;
               if (write_count != 16'hFFFF) write_count <= write_count + 16'd1;
            end else begin
               if (clip_count != 16'hFFFF) clip_count <= clip_count + 16'd1;
            end
         end
      end
   end

endmodule
